br_resolve_ctrl: RTL and testbench

Branch resolution controller for the pipelined LC-3b core. It owns the architectural NZP condition-code register and accepts one BR instruction at a time from decode. It evaluates the instruction's n/z/p mask against the current NZP, waiting for in-flight CC writers where necessary. On a taken branch it issues a redirect to fetch with a valid/ready handshake, then drives a fixed-length flush window into the front end.

---
 rtl/br_resolve_ctrl.sv | 150 +++++++++++++++
 tb/tb_br_resolve_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/br_resolve_ctrl.sv
// Branch resolution controller: owns the NZP condition codes, resolves one BR
// at a time, issues a redirect to fetch and then holds a fixed flush window.
// Optional feature macro: BR_STATS_EN (taken/total saturating branch counters).
module br_resolve_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cc_wr_valid,
  input  logic [15:0] cc_wr_data,
  input  logic        cc_busy,
  input  logic        br_valid,
  output logic        br_ready,
  input  logic [15:0] br_ir,
  input  logic [15:0] br_target,
  output logic        redirect_valid,
  input  logic        redirect_ready,
  output logic [15:0] redirect_pc,
  output logic        flush,
  output logic        stall,
  output logic [2:0]  nzp,
  output logic [15:0] stat_taken,
  output logic [15:0] stat_total
);

  localparam int unsigned WORD_W = 16;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned IRQ_W  = 7;  // opcode[15:12] + mask[11:9]
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(FLUSH_CYCLES);
  localparam logic [2:0] NZP_RESET = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_EVAL     = 2'd1,
    ST_REDIRECT = 2'd2,
    ST_FLUSH    = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IRQ_W-1:0]    ir_q, ir_d;
  logic [WORD_W-1:0]   tgt_q, tgt_d;
  logic [2:0]          nzp_q;
  logic [2:0]          nzp_wr;
  logic [2:0]          nzp_eff;
  logic                taken;

  // One-hot NZP derived from a result word.
  function automatic logic [2:0] derive_nzp(input logic [WORD_W-1:0] w);
    if (w[WORD_W-1])            return 3'b100;
    else if (w == WORD_W'(0))   return 3'b010;
    else                        return 3'b001;
  endfunction

  assign nzp_wr  = derive_nzp(cc_wr_data);
  assign nzp_eff = cc_wr_valid ? nzp_wr : nzp_q;

  // Architectural condition-code register, written by any CC writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           nzp_q <= NZP_RESET;
    else if (cc_wr_valid) nzp_q <= nzp_wr;
  end

  // State, flush counter and latched branch candidate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ir_q    <= '0;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ir_q    <= ir_d;
      tgt_q   <= tgt_d;
    end
  end

  // Next-state logic: accept, resolve (with CC forwarding), redirect, flush.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ir_d    = ir_q;
    tgt_d   = tgt_q;
    taken   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (br_valid) begin
          ir_d    = br_ir[15:9];
          tgt_d   = br_target;
          state_d = ST_EVAL;
        end
      end
      ST_EVAL: begin
        if (!cc_busy) begin
          taken   = (ir_q[6:3] == 4'b0000) && ((ir_q[2:0] & nzp_eff) != 3'b000);
          state_d = taken ? ST_REDIRECT : ST_IDLE;
        end
      end
      ST_REDIRECT: begin
        if (redirect_ready) begin
          if (FLUSH_CYCLES == 0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_FLUSH;
            cnt_d   = CNT_INIT;
          end
        end
      end
      ST_FLUSH: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decode directly from the state register so reset clears them at once.
  assign br_ready       = (state_q == ST_IDLE);
  assign redirect_valid = (state_q == ST_REDIRECT);
  assign redirect_pc    = tgt_q;
  assign flush          = (state_q == ST_FLUSH);
  assign stall          = (state_q == ST_EVAL) && cc_busy;
  assign nzp            = nzp_q;

`ifdef BR_STATS_EN
  logic              resolve;
  logic [WORD_W-1:0] taken_q, total_q;

  assign resolve = (state_q == ST_EVAL) && !cc_busy;

  // Saturating resolution counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_q <= '0;
      total_q <= '0;
    end else if (resolve) begin
      if (total_q != '1)          total_q <= total_q + WORD_W'(1);
      if (taken && taken_q != '1) taken_q <= taken_q + WORD_W'(1);
    end
  end

  assign stat_taken = taken_q;
  assign stat_total = total_q;
`else
  assign stat_taken = '0;
  assign stat_total = '0;
`endif

endmodule

// File: tb/tb_br_resolve_ctrl.sv
// Directed self-checking bench for br_resolve_ctrl (FLUSH_CYCLES=2 and 0).
`timescale 1ns/1ps
module tb_br_resolve_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cc_wr_valid;
  logic [15:0] cc_wr_data;
  logic        cc_busy;
  logic        br_valid;
  logic [15:0] br_ir;
  logic [15:0] br_target;
  logic        redirect_ready;

  logic        br_ready, redirect_valid, flush, stall;
  logic [15:0] redirect_pc, stat_taken, stat_total;
  logic [2:0]  nzp;

  logic        z_br_ready, z_redirect_valid, z_flush, z_stall;
  logic [15:0] z_redirect_pc, z_stat_taken, z_stat_total;
  logic [2:0]  z_nzp;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  br_resolve_ctrl #(.FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .cc_wr_valid(cc_wr_valid), .cc_wr_data(cc_wr_data),
    .cc_busy(cc_busy), .br_valid(br_valid), .br_ready(br_ready), .br_ir(br_ir),
    .br_target(br_target), .redirect_valid(redirect_valid),
    .redirect_ready(redirect_ready), .redirect_pc(redirect_pc), .flush(flush),
    .stall(stall), .nzp(nzp), .stat_taken(stat_taken), .stat_total(stat_total)
  );

  br_resolve_ctrl #(.FLUSH_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .cc_wr_valid(cc_wr_valid), .cc_wr_data(cc_wr_data),
    .cc_busy(cc_busy), .br_valid(br_valid), .br_ready(z_br_ready), .br_ir(br_ir),
    .br_target(br_target), .redirect_valid(z_redirect_valid),
    .redirect_ready(redirect_ready), .redirect_pc(z_redirect_pc), .flush(z_flush),
    .stall(z_stall), .nzp(z_nzp), .stat_taken(z_stat_taken), .stat_total(z_stat_total)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Taken branch with immediate handshake; checks both flush-length variants.
  task automatic taken_br(input string tag, input logic [15:0] ir, input logic [15:0] tgt);
    br_valid = 1'b1; br_ir = ir; br_target = tgt;
    cyc();
    br_valid = 1'b0;
    chk({tag, "_eval_ready"}, 32'(br_ready), 32'd0);
    cyc();
    chk({tag, "_rv"}, 32'(redirect_valid), 32'd1);
    chk({tag, "_pc"}, 32'(redirect_pc), 32'(tgt));
    redirect_ready = 1'b1;
    cyc();
    redirect_ready = 1'b0;
    chk({tag, "_flush1"}, 32'(flush), 32'd1);
    chk({tag, "_rv_off"}, 32'(redirect_valid), 32'd0);
    chk({tag, "_z_flush"}, 32'(z_flush), 32'd0);
    chk({tag, "_z_idle"}, 32'(z_br_ready), 32'd1);
    cyc();
    chk({tag, "_flush2"}, 32'(flush), 32'd1);
    chk({tag, "_z_flush2"}, 32'(z_flush), 32'd0);
    cyc();
    chk({tag, "_flush_end"}, 32'(flush), 32'd0);
    chk({tag, "_ready_back"}, 32'(br_ready), 32'd1);
  endtask

  // Not-taken branch without stall: ready again in cycle 2.
  task automatic nt_br(input string tag, input logic [15:0] ir);
    br_valid = 1'b1; br_ir = ir; br_target = 16'hDEAD;
    cyc();
    br_valid = 1'b0;
    chk({tag, "_eval_ready"}, 32'(br_ready), 32'd0);
    cyc();
    chk({tag, "_ready"}, 32'(br_ready), 32'd1);
    chk({tag, "_rv"}, 32'(redirect_valid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; cc_wr_valid = 1'b0; cc_wr_data = '0; cc_busy = 1'b0;
    br_valid = 1'b0; br_ir = '0; br_target = '0; redirect_ready = 1'b0;
    #12;
    chk("rst_nzp", 32'(nzp), 32'h2);
    chk("rst_ready", 32'(br_ready), 32'd1);
    chk("rst_rv", 32'(redirect_valid), 32'd0);
    chk("rst_pc", 32'(redirect_pc), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_stat_total", 32'(stat_total), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    #1;

    // Reset NZP=010 with mask 010.
    taken_br("t_rstnzp", 16'h0405, 16'h3000);

    // CC update to negative, mask 100 taken, mask 011 not taken.
    cc_wr_valid = 1'b1; cc_wr_data = 16'h8000;
    cyc();
    cc_wr_valid = 1'b0;
    chk("cc_nzp_neg", 32'(nzp), 32'h4);
    taken_br("t_neg", 16'h0800, 16'h4242);
    nt_br("nt_zp", 16'h0600);

    // Stall for 3 cycles, then release with forwarded positive result.
    cc_busy = 1'b1;
    br_valid = 1'b1; br_ir = 16'h0200; br_target = 16'h5A5A;
    cyc();
    br_valid = 1'b0;
    chk("stall_c1", 32'(stall), 32'd1);
    cyc();
    chk("stall_c2", 32'(stall), 32'd1);
    cyc();
    chk("stall_c3", 32'(stall), 32'd1);
    chk("stall_rv", 32'(redirect_valid), 32'd0);
    cc_busy = 1'b0; cc_wr_valid = 1'b1; cc_wr_data = 16'h0005;
    #1;
    chk("stall_release", 32'(stall), 32'd0);
    cyc();
    cc_wr_valid = 1'b0;
    chk("fwd_taken", 32'(redirect_valid), 32'd1);
    chk("fwd_nzp", 32'(nzp), 32'h1);
    // Backpressure: 4 cycles with redirect_ready low.
    for (int i = 0; i < 4; i++) begin
      chk("bp_rv", 32'(redirect_valid), 32'd1);
      chk("bp_pc", 32'(redirect_pc), 32'h5A5A);
      chk("bp_noflush", 32'(flush), 32'd0);
      cyc();
    end
    chk("bp_rv_last", 32'(redirect_valid), 32'd1);
    redirect_ready = 1'b1;
    cyc();
    redirect_ready = 1'b0;
    chk("bp_flush1", 32'(flush), 32'd1);
    cyc();
    chk("bp_flush2", 32'(flush), 32'd1);
    cyc();
    chk("bp_flush_end", 32'(flush), 32'd0);
    chk("bp_ready", 32'(br_ready), 32'd1);

    // Edge opcodes: ADD, NOP mask, non-BR opcode with full mask.
    nt_br("nt_add", 16'h1000);
    nt_br("nt_nop", 16'h0000);
    nt_br("nt_op1_m111", 16'h1E00);

    // Async reset in the middle of a flush window.
    br_valid = 1'b1; br_ir = 16'h0E00; br_target = 16'h7777;
    cyc();
    br_valid = 1'b0;
    cyc();
    chk("ar_rv", 32'(redirect_valid), 32'd1);
    redirect_ready = 1'b1;
    cyc();
    redirect_ready = 1'b0;
    chk("ar_flush_pre", 32'(flush), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_flush_now", 32'(flush), 32'd0);
    chk("ar_nzp", 32'(nzp), 32'h2);
    chk("ar_pc", 32'(redirect_pc), 32'd0);
    chk("ar_stat_total", 32'(stat_total), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    cyc();
    chk("ar_no_residual_flush", 32'(flush), 32'd0);
    chk("ar_no_residual_rv", 32'(redirect_valid), 32'd0);
    chk("ar_ready", 32'(br_ready), 32'd1);

    // Three branches, two taken.
    taken_br("s_t1", 16'h0E00, 16'h0100);
    taken_br("s_t2", 16'h0400, 16'h0200);
    nt_br("s_nt", 16'h0200);
`ifdef BR_STATS_EN
    chk("stat_total", 32'(stat_total), 32'd3);
    chk("stat_taken", 32'(stat_taken), 32'd2);
`else
    chk("stat_total_tied", 32'(stat_total), 32'd0);
    chk("stat_taken_tied", 32'(stat_taken), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
